// File: rtl/traffic_light_fsm.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_fsm
// Description : Phase-sequencing FSM for a two-phase intersection. Advances
//               on the timing controller's one-cycle timing_done pulse.
//               Supports demand-based green extension, emergency preemption
//               held in ALL_RED, and a flashing-red fallback mode. All lamp
//               and status outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================

// State codes shared with timing_controller. They are only defined here if
// the shared macro header has not already provided them.
`ifndef TL_PHASE_1_GREEN
`define TL_PHASE_1_GREEN  4'h0
`endif
`ifndef TL_PHASE_1_YELLOW
`define TL_PHASE_1_YELLOW 4'h1
`endif
`ifndef TL_ALL_RED
`define TL_ALL_RED        4'h2
`endif
`ifndef TL_PHASE_2_GREEN
`define TL_PHASE_2_GREEN  4'h3
`endif
`ifndef TL_PHASE_2_YELLOW
`define TL_PHASE_2_YELLOW 4'h4
`endif

module traffic_light_fsm #(
  parameter int BLINK_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       timing_done,
  input  logic       en,
  input  logic       preempt,
  input  logic       p1_demand,
  input  logic       p2_demand,
  output logic [3:0] current_state,
  output logic [2:0] p1_lights,
  output logic [2:0] p2_lights,
  output logic       preempt_active,
  output logic       state_changed
);

  typedef enum logic [3:0] {
    PHASE_1_GREEN  = `TL_PHASE_1_GREEN,
    PHASE_1_YELLOW = `TL_PHASE_1_YELLOW,
    ALL_RED        = `TL_ALL_RED,
    PHASE_2_GREEN  = `TL_PHASE_2_GREEN,
    PHASE_2_YELLOW = `TL_PHASE_2_YELLOW,
    FLASH          = 4'hF
  } state_t;

  // Blink counter is wide enough for 0..BLINK_TICKS-1 (at least one bit).
  localparam int               CNT_W     = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(BLINK_TICKS - 1);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  // Lamp encodings, {red, yellow, green}.
  localparam logic [2:0] c_lamp_red = 3'b100;
  localparam logic [2:0] c_lamp_yel = 3'b010;
  localparam logic [2:0] c_lamp_grn = 3'b001;

  // next_phase encoding: which green is served after ALL_RED.
  localparam logic c_serve_p1 = 1'b0;
  localparam logic c_serve_p2 = 1'b1;

  // Registered state.
  state_t           r_state;
  logic             r_next_phase;
  logic [CNT_W-1:0] r_blink_cnt;
  logic             r_blink;
  logic [2:0]       r_p1_lights;
  logic [2:0]       r_p2_lights;
  logic             r_preempt_active;
  logic             r_state_changed;

  // Next-cycle values.
  state_t           w_state_next;
  logic             w_next_phase_next;
  logic [CNT_W-1:0] w_blink_cnt_next;
  logic             w_blink_next;
  logic [2:0]       w_p1_lights_next;
  logic [2:0]       w_p2_lights_next;
  logic             w_preempt_active_next;
  logic             w_state_changed_next;

  // State register and all registered outputs; reset forces all-red at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= ALL_RED;
      r_next_phase     <= c_serve_p1;
      r_blink_cnt      <= '0;
      r_blink          <= 1'b0;
      r_p1_lights      <= c_lamp_red;
      r_p2_lights      <= c_lamp_red;
      r_preempt_active <= 1'b0;
      r_state_changed  <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_next_phase     <= w_next_phase_next;
      r_blink_cnt      <= w_blink_cnt_next;
      r_blink          <= w_blink_next;
      r_p1_lights      <= w_p1_lights_next;
      r_p2_lights      <= w_p2_lights_next;
      r_preempt_active <= w_preempt_active_next;
      r_state_changed  <= w_state_changed_next;
    end
  end

  // Next-state, next-phase, blink and preemption-status decisions.
  always_comb begin
    w_state_next          = r_state;
    w_next_phase_next     = r_next_phase;
    w_blink_cnt_next      = r_blink_cnt;
    w_blink_next          = r_blink;
    w_preempt_active_next = r_preempt_active;

    case (r_state)
      // A green is extended for another dwell unless the other phase wants
      // service, preemption is requested, or flash mode is requested.
      PHASE_1_GREEN: begin
        if (timing_done && (p2_demand || preempt || !en)) begin
          w_state_next = PHASE_1_YELLOW;
        end
      end

      PHASE_2_GREEN: begin
        if (timing_done && (p1_demand || preempt || !en)) begin
          w_state_next = PHASE_2_YELLOW;
        end
      end

      PHASE_1_YELLOW: begin
        if (timing_done) begin
          w_state_next      = ALL_RED;
          w_next_phase_next = c_serve_p2;
        end
      end

      PHASE_2_YELLOW: begin
        if (timing_done) begin
          w_state_next      = ALL_RED;
          w_next_phase_next = c_serve_p1;
        end
      end

      // Flash request outranks preemption; preemption holds ALL_RED.
      ALL_RED: begin
        if (timing_done) begin
          if (!en) begin
            w_state_next          = FLASH;
            w_preempt_active_next = 1'b0;
          end else if (preempt) begin
            w_preempt_active_next = 1'b1;
          end else begin
            w_state_next          = (r_next_phase == c_serve_p2) ? PHASE_2_GREEN
                                                                 : PHASE_1_GREEN;
            w_preempt_active_next = 1'b0;
          end
        end
      end

      // Flash ignores timing_done; leaves as soon as en returns.
      FLASH: begin
        if (en) begin
          w_state_next      = ALL_RED;
          w_next_phase_next = c_serve_p1;
          w_blink_cnt_next  = '0;
        end else if (r_blink_cnt == c_cnt_max) begin
          w_blink_cnt_next = '0;
          w_blink_next     = ~r_blink;
        end else begin
          w_blink_cnt_next = r_blink_cnt + c_cnt_one;
        end
      end

      // Any unrecognised code recovers to the safe all-red state.
      default: begin
        w_state_next          = ALL_RED;
        w_preempt_active_next = 1'b0;
      end
    endcase
  end

  // Lamp decode from the upcoming state so lamps move on the same edge.
  always_comb begin
    w_p1_lights_next = c_lamp_red;
    w_p2_lights_next = c_lamp_red;
    case (w_state_next)
      PHASE_1_GREEN:  w_p1_lights_next = c_lamp_grn;
      PHASE_1_YELLOW: w_p1_lights_next = c_lamp_yel;
      PHASE_2_GREEN:  w_p2_lights_next = c_lamp_grn;
      PHASE_2_YELLOW: w_p2_lights_next = c_lamp_yel;
      FLASH: begin
        w_p1_lights_next = {w_blink_next, 2'b00};
        w_p2_lights_next = {w_blink_next, 2'b00};
      end
      default: begin
        w_p1_lights_next = c_lamp_red;
        w_p2_lights_next = c_lamp_red;
      end
    endcase
  end

  // Change flag is registered alongside the state it reports.
  always_comb begin
    w_state_changed_next = (w_state_next != r_state);
  end

  assign current_state  = r_state;
  assign p1_lights      = r_p1_lights;
  assign p2_lights      = r_p2_lights;
  assign preempt_active = r_preempt_active;
  assign state_changed  = r_state_changed;

endmodule

`default_nettype wire
